// File: rtl/fp_to_twos.sv
// fp_to_twos: converts the lab 8-bit float {sign, exponent, significand} into an
// OUT_W-bit two's-complement value, V = (-1)^sign * significand * 2^exponent.
// Valid/ready on both sides, one operation in flight at a time.
// Build option: FP2TC_FAST_SHIFT_EN
//   undefined (default) - iterative shifter, one exponent step per clock
//   defined             - single-cycle barrel shift, result registered on accept
// OUT_W must be >= SIG_W + 2**EXP_W so the shift can never overflow.
module fp_to_twos #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [EXP_W-1:0] exponent,
  input  logic [SIG_W-1:0] significand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] twos_complement
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_result;
  logic [OUT_W-1:0] w_mag_in;

  // Significand zero-extended to the result width; all shifting is unsigned.
  assign w_mag_in = {{(OUT_W-SIG_W){1'b0}}, significand};

  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_valid;
  assign twos_complement = r_result;

`ifdef FP2TC_FAST_SHIFT_EN

  logic [OUT_W-1:0] w_shifted;
  logic [OUT_W-1:0] w_signed;

  // Whole conversion done combinationally from the live inputs.
  assign w_shifted = w_mag_in << exponent;
  assign w_signed  = sign ? (~w_shifted + OUT_W'(1)) : w_shifted;

  // Handshake FSM: the accepting edge registers the result and goes straight to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_result    <= w_signed;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`else

  logic [OUT_W-1:0] r_mag;
  logic [EXP_W-1:0] r_cnt;
  logic             r_sign;
  logic [OUT_W-1:0] w_signed;

  // Negate only once, after the magnitude has been fully shifted.
  assign w_signed = r_sign ? (~r_mag + OUT_W'(1)) : r_mag;

  // Handshake FSM with iterative shifter: one left shift per clock until cnt hits zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign     <= sign;
            r_cnt      <= exponent;
            r_mag      <= w_mag_in;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt - EXP_W'(1);
          end else begin
            r_result    <= w_signed;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`endif

endmodule
